mem_march_initiator: RTL and testbench
======================================

Name: mem_march_initiator

Overview:
- Host-side initiator that drives the pin-level interface of the team's byte-wide DFF memory and checks it.
- Memory interface it drives: address, write enable, write data. Read data is registered, one cycle after address. A write cycle returns the old contents.
- Runs a three-phase march test (W0, R0W1, R1) and reports pass/fail, error count and the first failing location.
- Sits in the test harness / BIST wrapper beside the memory and connects directly to the memory's address, write-enable, write-data and read-data pins.

Parameters:
- RAM_BYTES, 32, number of byte locations tested (>=2); addresses 0..RAM_BYTES-1.
- ADDR_BITS, $clog2(RAM_BYTES), width of mem_addr and fail_addr.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, level sampled each cycle; begins a test when in IDLE or DONE.
- pattern, input, 8, background byte; sampled and held internally on an accepted start.
- mem_addr, output, ADDR_BITS, registered address to the memory.
- mem_wr_en, output, 1, registered write enable to the memory.
- mem_wdata, output, 8, registered write data to the memory.
- mem_rdata, input, 8, memory read data; holds data for the address presented in the previous cycle.
- busy, output, 1, high while the test runs (W0 through DRAIN).
- done, output, 1, level; high from test completion until the next accepted start or rst.
- pass, output, 1, valid when done; 1 if err_count==0.
- err_count, output, 8, number of mismatches, saturating at 255.
- fail_addr, output, ADDR_BITS, address of the first mismatch.
- fail_data, output, 8, read byte at the first mismatch.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE.
  - Reset values: mem_addr=0, mem_wr_en=0, mem_wdata=0, busy=0, done=0, pass=0, err_count=0, fail_addr=0, fail_data=0.
  - The compare pipeline is cleared.
  - Reset mid-test aborts at once; mem_wr_en is 0 in the following cycle.
- States: IDLE, W0, R0W1, R1, DRAIN, DONE.
  - Let P be the latched pattern and N = RAM_BYTES.
- Start:
  - start=1 at an edge in IDLE or DONE: latch P, clear done, err_count, fail_* and pass, then go to W0.
  - start is ignored in W0, R0W1, R1 and DRAIN.
- W0, N cycles:
  - mem_addr ascends 0..N-1, mem_wr_en=1, mem_wdata=P.
  - No compares.
- R0W1, N cycles:
  - mem_addr ascends 0..N-1, mem_wr_en=1, mem_wdata=~P.
  - Each cycle is also a read with expected value P; old data is returned.
- R1, N cycles:
  - mem_addr descends N-1..0, mem_wr_en=0, mem_wdata=0.
  - Expected value ~P.
- DRAIN, 1 cycle:
  - mem_wr_en=0, mem_addr=0.
  - Completes the final compare.
- DONE:
  - mem_* outputs are 0, busy=0, done=1, pass=(err_count==0).
  - State holds until start or rst.
- Compare pipeline:
  - For a read issued in cycle k, register {valid, expected, addr}. mem_rdata is compared in cycle k+1 and the result is registered at the end of k+1.
  - Compares overlap the phase transitions (R0W1→R1, R1→DRAIN) without stalls.
- On a mismatch:
  - err_count increments, saturating at 255.
  - fail_addr and fail_data capture only when err_count was 0 before the increment.
- Timing:
  - start sampled at the end of cycle 0 ⇒ busy=1 in cycles 1..3N+1 and done=1 from cycle 3N+2.
  - For N=32, done rises in cycle 98.
  - err_count and fail_* are final when done rises.
- mem_* outputs are glitch-free registers; address counters never exceed N-1 or wrap mid-phase.

Test Plan:
- Bench memory model matches the DFF memory: registered read, read-old-on-write, reset to 0 (bench inverts rst for the model).
1. Healthy memory, N=32, pattern=0x55, start in cycle 0 → busy cycles 1..97, done=1 in cycle 98, pass=1, err_count=0; final memory contents all 0xAA.
2. Model bit 3 of addr 7 stuck at 0, pattern=0x00 → R1 reads 0xF7 at addr 7; err_count=1, fail_addr=7, fail_data=0xF7, pass=0.
3. Model drops writes to addr 31, pattern=0xA5 → R0W1 mismatch (0x00 vs 0xA5) and R1 mismatch (0x00 vs 0x5A); err_count=2, fail_addr=31, fail_data=0x00.
4. start held 1 again in cycle 40 → ignored, done still in cycle 98. start in cycle 100 → done=0 in cycle 101 and the test reruns, done in cycle 198.
5. rst=1 in cycle 50 → cycle 51: busy=0, mem_wr_en=0, done=0, err_count=0. start in cycle 55 → full test, done in cycle 153.
6. Address trace → W0: mem_addr 0..31 ascending with wdata=pattern. R0W1: mem_addr 0..31 with wdata=~pattern. R1: mem_addr 31..0 with mem_wr_en=0.

Source files
------------

// File: rtl/mem_march_initiator_if.sv
// rtl/mem_march_initiator_if.sv - pin bundle between the march initiator and the byte-wide DFF memory
//   mem_addr  : location presented to the memory this cycle
//   mem_wr_en : write strobe for mem_addr
//   mem_wdata : byte written when mem_wr_en is high
//   mem_rdata : registered read data for the address presented in the previous cycle
//   master    : initiator side, drives address/strobe/data and samples rdata
//   slave     : memory side
interface mem_march_initiator_if #(
  parameter int ADDR_BITS = 5
);
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_wr_en;
  logic [7:0]           mem_wdata;
  logic [7:0]           mem_rdata;

  modport master (
    output mem_addr,
    output mem_wr_en,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_march_initiator.sv
// rtl/mem_march_initiator.sv - three-phase march test (W0, R0W1, R1) initiator for the byte-wide DFF memory
//   clk, rst   : single clock, synchronous active-high reset
//   start      : begins a test when idle or done; pattern is latched at that edge
//   pattern    : background byte P
//   mem        : memory pin bundle (master side), all outputs registered
//   busy       : high from W0 through DRAIN
//   done, pass : done is a level until the next accepted start; pass = no mismatches
//   err_count  : saturating mismatch count
//   fail_addr  : address of the first mismatch
//   fail_data  : byte read back at the first mismatch
module mem_march_initiator #(
  parameter int RAM_BYTES = 32,
  parameter int ADDR_BITS = $clog2(RAM_BYTES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           pattern,
  mem_march_initiator_if.master mem,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           err_count,
  output logic [ADDR_BITS-1:0] fail_addr,
  output logic [7:0]           fail_data
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(RAM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    W0,
    R0W1,
    R1,
    DRAIN,
    DONE
  } state_t;

  state_t               state;
  logic [7:0]           pat;

  // Compare stage: describes the read issued in the previous cycle.
  logic                 cmp_valid;
  logic [7:0]           cmp_exp;
  logic [ADDR_BITS-1:0] cmp_addr;

  logic                 mismatch;
  logic [7:0]           err_next;

  always_comb begin
    mismatch = cmp_valid && (mem.mem_rdata != cmp_exp);
    err_next = err_count;
    if (mismatch && (err_count != 8'hFF)) begin
      err_next = err_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pat           <= 8'h00;
      mem.mem_addr  <= '0;
      mem.mem_wr_en <= 1'b0;
      mem.mem_wdata <= 8'h00;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= 8'h00;
      fail_addr     <= '0;
      fail_data     <= 8'h00;
      cmp_valid     <= 1'b0;
      cmp_exp       <= 8'h00;
      cmp_addr      <= '0;
    end else begin
      // The compare stage runs every cycle regardless of state, so the last
      // read of one phase is checked while the next phase is already issuing.
      cmp_valid <= (state == R0W1) || (state == R1);
      cmp_exp   <= (state == R0W1) ? pat : ~pat;
      cmp_addr  <= mem.mem_addr;
      err_count <= err_next;
      if (mismatch && (err_count == 8'h00)) begin
        fail_addr <= cmp_addr;
        fail_data <= mem.mem_rdata;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            pat           <= pattern;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= 8'h00;
            fail_addr     <= '0;
            fail_data     <= 8'h00;
            busy          <= 1'b1;
            mem.mem_addr  <= '0;
            mem.mem_wr_en <= 1'b1;
            mem.mem_wdata <= pattern;
            state         <= W0;
          end
        end
        W0: begin
          if (mem.mem_addr == LAST_ADDR) begin
            mem.mem_addr  <= '0;
            mem.mem_wdata <= ~pat;
            state         <= R0W1;
          end else begin
            mem.mem_addr <= mem.mem_addr + 1'b1;
          end
        end
        R0W1: begin
          // Each write here also returns the old contents, which must be P.
          if (mem.mem_addr == LAST_ADDR) begin
            mem.mem_wr_en <= 1'b0;
            mem.mem_wdata <= 8'h00;
            state         <= R1;
          end else begin
            mem.mem_addr <= mem.mem_addr + 1'b1;
          end
        end
        R1: begin
          // Address stays at LAST_ADDR on entry and descends to 0.
          if (mem.mem_addr == '0) begin
            state <= DRAIN;
          end else begin
            mem.mem_addr <= mem.mem_addr - 1'b1;
          end
        end
        DRAIN: begin
          // The final R1 compare resolves this cycle; err_next is its outcome.
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_next == 8'h00);
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_march_initiator.sv
// tb/tb_mem_march_initiator.sv - directed bench for mem_march_initiator with a DFF memory model
module tb_mem_march_initiator;

  localparam int N  = 32;
  localparam int AB = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    pattern = 8'h00;
  logic          busy, done, pass;
  logic [7:0]    err_count;
  logic [AB-1:0] fail_addr;
  logic [7:0]    fail_data;

  mem_march_initiator_if #(.ADDR_BITS(AB)) bus ();

  mem_march_initiator #(.RAM_BYTES(N), .ADDR_BITS(AB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .mem       (bus.master),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, old data on write, clears on reset.
  // fault 1: bit 3 of addr 7 stuck at 0; fault 2: writes to addr 31 dropped.
  int         fault = 0;
  logic       model_rst_n;
  logic [7:0] mem_m [0:N-1];
  assign model_rst_n = ~rst;

  always @(posedge clk) begin
    if (!model_rst_n) begin
      for (int i = 0; i < N; i++) mem_m[i] <= 8'h00;
      bus.mem_rdata <= 8'h00;
    end else begin
      bus.mem_rdata <= mem_m[bus.mem_addr];
      if (bus.mem_wr_en && !(fault == 2 && bus.mem_addr == 5'd31)) begin
        mem_m[bus.mem_addr] <= (fault == 1 && bus.mem_addr == 5'd7) ?
                               (bus.mem_wdata & 8'hF7) : bus.mem_wdata;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Results recorded by run()
  int   busy_first, busy_last, rise1, rise2, fall1, trace_err;
  logic snap_busy, snap_wr, snap_done;
  logic [7:0] snap_err;

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Cycle 0 is the cycle whose closing edge samples the first start.
  task automatic run(input logic [7:0] p, input int ncyc, input int s2, input int s3, input int r_at);
    logic prev_done;
    int   k, ea;
    logic ew;
    logic [7:0] ed;
    busy_first = -1; busy_last = -1; rise1 = -1; rise2 = -1; fall1 = -1; trace_err = 0;
    prev_done = done;
    pattern = p;
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (c == s2) || (c == s3);
      rst   = (c == r_at);
      @(posedge clk);
      #1;
      k = c + 1;
      if (busy && busy_first < 0) busy_first = k;
      if (busy && rise1 < 0) busy_last = k;
      if (done && !prev_done) begin
        if (rise1 < 0) rise1 = k;
        else if (rise2 < 0) rise2 = k;
      end
      if (!done && prev_done && fall1 < 0) fall1 = k;
      prev_done = done;
      if (k == r_at + 1) begin
        snap_busy = busy; snap_wr = bus.mem_wr_en; snap_done = done; snap_err = err_count;
      end
      if (k >= 1 && k <= 3 * N + 1) begin
        if (k <= N)            begin ea = k - 1;     ew = 1'b1; ed = p;     end
        else if (k <= 2 * N)   begin ea = k - N - 1; ew = 1'b1; ed = ~p;    end
        else if (k <= 3 * N)   begin ea = 3 * N - k; ew = 1'b0; ed = 8'h00; end
        else                   begin ea = 0;         ew = 1'b0; ed = 8'h00; end
        if (bus.mem_addr !== AB'(ea) || bus.mem_wr_en !== ew || bus.mem_wdata !== ed)
          trace_err++;
      end
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    int bad;

    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_wr_en", bus.mem_wr_en, 0);
    check("rst_addr", bus.mem_addr, 0);

    // 1 + 6: healthy memory, pattern 0x55, with address trace
    fault = 0;
    run(8'h55, 100, -1, -1, -1);
    check("t1_busy_first", busy_first, 1);
    check("t1_busy_last", busy_last, 97);
    check("t1_done_cycle", rise1, 98);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_trace", trace_err, 0);
    bad = 0;
    for (int i = 0; i < N; i++) if (mem_m[i] !== 8'hAA) bad++;
    check("t1_mem_final", bad, 0);

    // 2: stuck bit 3 at addr 7, pattern 0x00
    do_reset();
    fault = 1;
    run(8'h00, 100, -1, -1, -1);
    check("t2_done_cycle", rise1, 98);
    check("t2_err", err_count, 1);
    check("t2_fail_addr", fail_addr, 7);
    check("t2_fail_data", fail_data, 8'hF7);
    check("t2_pass", pass, 0);

    // 3: writes to addr 31 dropped, pattern 0xA5
    do_reset();
    fault = 2;
    run(8'hA5, 100, -1, -1, -1);
    check("t3_err", err_count, 2);
    check("t3_fail_addr", fail_addr, 31);
    check("t3_fail_data", fail_data, 8'h00);
    check("t3_pass", pass, 0);
    check("t3_trace", trace_err, 0);

    // 4: start during W/R phases ignored, restart from DONE
    do_reset();
    fault = 0;
    run(8'h3C, 205, 40, 100, -1);
    check("t4_done_cycle", rise1, 98);
    check("t4_done_fall", fall1, 101);
    check("t4_redone_cycle", rise2, 198);
    check("t4_pass", pass, 1);

    // 5: reset mid-test, then a fresh test
    do_reset();
    run(8'h0F, 160, 55, -1, 50);
    check("t5_busy_after_rst", snap_busy, 0);
    check("t5_wr_after_rst", snap_wr, 0);
    check("t5_done_after_rst", snap_done, 0);
    check("t5_err_after_rst", snap_err, 0);
    check("t5_done_cycle", rise1, 153);
    check("t5_pass", pass, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
